// File: rtl/syzygy_adc_capture_pkg.sv
// ---------------------------------------------------------------------------
// syzygy_adc_capture_pkg
//   Shared definitions for the ADC capture block and the host register-map
//   logic: FSM state encodings and the width helper for capture_len and the
//   sample counters.
// ---------------------------------------------------------------------------
package syzygy_adc_capture_pkg;

    // FSM state encodings; the numeric values are visible to software
    // through the state port, so they must not be reordered.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_READOUT = 2'd3
    } adc_state_t;

    // capture_len and the counters carry one bit more than the RAM address,
    // so a full-depth capture length is representable without wrapping.
    function automatic int cap_len_width(input int depth_log2);
        return depth_log2 + 1;
    endfunction

endpackage

// File: rtl/syzygy_adc_capture_ram.sv
// ---------------------------------------------------------------------------
// syzygy_adc_capture_ram
//   Simple dual-port capture RAM: one write port, one read port with a
//   registered (1-cycle latency) output. The read register only updates when
//   rd_en is high, so it doubles as the readout prefetch stage.
// Ports
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_en    in   read strobe; rd_data updates on the following edge
//   rd_addr  in   read address
//   rd_data  out  registered read data, held while rd_en is low
// ---------------------------------------------------------------------------
module syzygy_adc_capture_ram #(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    // No reset on the array or the read register so the tools can map this
    // onto a block RAM with its output register.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/syzygy_adc_capture.sv
// ---------------------------------------------------------------------------
// syzygy_adc_capture
//   Receive-side ADC capture. Waits for a software trigger or a rising
//   threshold crossing, records a programmable number of samples into the
//   capture RAM, then streams them out over a valid/ready port.
// Ports
//   clk, reset_n    clock, asynchronous active-low reset
//   adc_data/valid  registered ADC sample and its qualifier
//   arm/abort       one-cycle control pulses (abort wins)
//   sw_trig         software trigger, honoured only while ARMED
//   trig_en         enable the threshold-crossing trigger
//   trig_threshold  crossing level (unsigned compare)
//   capture_len     samples to record; 0 or larger than the RAM means full depth
//   rd_data/valid/ready/last  readout stream
//   state           current FSM state
//   done            high in the cycle the final beat handshakes
// ---------------------------------------------------------------------------
module syzygy_adc_capture
    import syzygy_adc_capture_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] adc_data,
    input  logic                  adc_valid,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  sw_trig,
    input  logic                  trig_en,
    input  logic [DATA_WIDTH-1:0] trig_threshold,
    input  logic [DEPTH_LOG2:0]   capture_len,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_last,
    output logic [1:0]            state,
    output logic                  done
);

    localparam int              CW        = cap_len_width(DEPTH_LOG2);
    localparam logic [CW-1:0]   DEPTH_VAL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [CW-1:0]   ONE       = CW'(1);

    adc_state_t            cur_state, next_state;
    logic [CW-1:0]         len_q, len_clamped, len_last;
    logic [CW-1:0]         wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] thr_q, prev, ram_q;
    logic                  en_q, prev_valid;
    logic                  crossing, trigger, arm_accept;
    logic                  wr_en, rd_en, adv_out;
    logic                  q_valid, q_last;

    assign len_clamped = ((capture_len == '0) || (capture_len > DEPTH_VAL))
                         ? DEPTH_VAL : capture_len;
    assign len_last    = len_q - ONE;
    assign arm_accept  = (cur_state == ST_IDLE) && arm && !abort;

    // A crossing needs a previous valid sample strictly below the threshold
    // followed by one at or above it, so a run that starts above the level
    // does not trigger immediately.
    assign crossing = adc_valid && en_q && prev_valid &&
                      (prev < thr_q) && (adc_data >= thr_q);
    assign trigger  = crossing || sw_trig;

    // The output register can take a new beat when it is empty or its current
    // beat is being accepted; a read is issued when the prefetch stage (the
    // RAM output register) is empty or is moving into the output register.
    assign adv_out = !rd_valid || rd_ready;
    assign rd_en   = (cur_state == ST_READOUT) && !abort && (rd_idx < len_q) &&
                     (!q_valid || adv_out);

    assign state = cur_state;

    // Next-state, RAM write strobe and done pulse. Abort overrides everything,
    // including the done pulse of a final beat in the same cycle.
    always_comb begin
        next_state = cur_state;
        wr_en      = 1'b0;
        done       = 1'b0;
        case (cur_state)
            ST_IDLE: begin
                if (arm)
                    next_state = ST_ARMED;
            end
            ST_ARMED: begin
                if (trigger) begin
                    wr_en      = adc_valid;
                    next_state = (adc_valid && (len_q == ONE)) ? ST_READOUT : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (adc_valid) begin
                    wr_en = 1'b1;
                    if (wr_idx == len_last)
                        next_state = ST_READOUT;
                end
            end
            ST_READOUT: begin
                if (rd_valid && rd_ready && rd_last) begin
                    done       = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
        if (abort) begin
            next_state = ST_IDLE;
            wr_en      = 1'b0;
            done       = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cur_state <= ST_IDLE;
        else
            cur_state <= next_state;
    end

    // Run configuration is captured when arm is accepted and held for the
    // whole run, so software may change the inputs while a capture is live.
    // The trigger history is restarted at the same moment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_q      <= '0;
            thr_q      <= '0;
            en_q       <= 1'b0;
            prev       <= '0;
            prev_valid <= 1'b0;
        end else if (arm_accept) begin
            len_q      <= len_clamped;
            thr_q      <= trig_threshold;
            en_q       <= trig_en;
            prev_valid <= 1'b0;
        end else if ((cur_state == ST_ARMED) && adc_valid) begin
            prev       <= adc_data;
            prev_valid <= 1'b1;
        end
    end

    // Write index advances only on samples that are actually written; it
    // stops at len_q because the last write leaves CAPTURE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            wr_idx <= '0;
        else if (arm_accept)
            wr_idx <= '0;
        else if (wr_en)
            wr_idx <= wr_idx + ONE;
    end

    // Readout pipeline: read index, prefetch-stage flags and the output
    // register. Outside READOUT, or on abort, the pipeline is flushed so no
    // stale beat survives into the next run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_idx   <= '0;
            q_valid  <= 1'b0;
            q_last   <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_data  <= '0;
        end else if (abort || (cur_state != ST_READOUT)) begin
            q_valid  <= 1'b0;
            q_last   <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            if (arm_accept)
                rd_idx <= '0;
        end else begin
            if (adv_out) begin
                rd_valid <= q_valid;
                rd_last  <= q_valid && q_last;
                if (q_valid)
                    rd_data <= ram_q;
            end
            if (rd_en) begin
                rd_idx  <= rd_idx + ONE;
                q_valid <= 1'b1;
                q_last  <= (rd_idx == len_last);
            end else if (adv_out) begin
                q_valid <= 1'b0;
                q_last  <= 1'b0;
            end
        end
    end

    syzygy_adc_capture_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_idx[DEPTH_LOG2-1:0]),
        .wr_data (adc_data),
        .rd_en   (rd_en),
        .rd_addr (rd_idx[DEPTH_LOG2-1:0]),
        .rd_data (ram_q)
    );

endmodule

// File: tb/tb_syzygy_adc_capture.sv
// ---------------------------------------------------------------------------
// tb_syzygy_adc_capture
//   Directed testbench for syzygy_adc_capture with hand-computed expected
//   beats for software/level triggers, backpressure, length clamping, gapped
//   input, abort and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_syzygy_adc_capture;

    localparam int DW    = 12;
    localparam int DL    = 10;
    localparam int DEPTH = 1 << DL;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] adc_data = '0;
    logic          adc_valid = 1'b0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic          sw_trig = 1'b0;
    logic          trig_en = 1'b0;
    logic [DW-1:0] trig_threshold = '0;
    logic [DL:0]   capture_len = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready = 1'b1;
    logic          rd_last;
    logic [1:0]    state;
    logic          done;

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] exp_q [$];

    syzygy_adc_capture #(
        .DATA_WIDTH (DW),
        .DEPTH_LOG2 (DL)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .adc_data       (adc_data),
        .adc_valid      (adc_valid),
        .arm            (arm),
        .abort          (abort),
        .sw_trig        (sw_trig),
        .trig_en        (trig_en),
        .trig_threshold (trig_threshold),
        .capture_len    (capture_len),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .rd_last        (rd_last),
        .state          (state),
        .done           (done)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_output(input string tag, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advance one clock; inputs driven after this take effect at the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_run(input logic [DL:0] len, input logic [DW-1:0] thr, input logic en);
        capture_len    = len;
        trig_threshold = thr;
        trig_en        = en;
        arm            = 1'b1;
        tick();
        arm            = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [DW-1:0] v, input logic valid);
        adc_data  = v;
        adc_valid = valid;
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic sw_trigger(input logic with_valid, input logic [DW-1:0] v);
        sw_trig   = 1'b1;
        adc_valid = with_valid;
        adc_data  = v;
        tick();
        sw_trig   = 1'b0;
        adc_valid = 1'b0;
    endtask

    // Drains the readout stream and compares it against exp_q.
    // mode 0: rd_ready always high; mode 1: rd_ready pattern 1,0,0 repeating.
    task automatic collect(input string tag, input int len, input int mode, input logic timing);
        int beat = 0;
        int cyc = 0;
        int ro_start = -1;
        int first_beat = -1;
        int last_beat = -1;
        int done_count = 0;
        logic stalled = 1'b0;
        logic [DW-1:0] hold_data = '0;
        logic hold_last = 1'b0;
        while (beat < len && cyc < len * 4 + 20) begin
            rd_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            #1;
            if (state == 2'd3 && ro_start < 0)
                ro_start = cyc;
            if (stalled) begin
                check_output({tag, "_stall_valid"}, 32'(rd_valid), 32'(1));
                check_output({tag, "_stall_data"}, 32'(rd_data), 32'(hold_data));
                check_output({tag, "_stall_last"}, 32'(rd_last), 32'(hold_last));
            end
            if (done)
                done_count++;
            if (rd_valid && rd_ready) begin
                if (first_beat < 0)
                    first_beat = cyc;
                last_beat = cyc;
                check_output({tag, "_data"}, 32'(rd_data), 32'(exp_q[beat]));
                check_output({tag, "_last"}, 32'(rd_last), 32'(beat == len - 1));
                check_output({tag, "_done"}, 32'(done), 32'(beat == len - 1));
                beat++;
            end
            stalled   = rd_valid && !rd_ready;
            hold_data = rd_data;
            hold_last = rd_last;
            tick();
            cyc++;
        end
        check_output({tag, "_beats"}, 32'(beat), 32'(len));
        check_output({tag, "_done_count"}, 32'(done_count), 32'(1));
        check_output({tag, "_end_state"}, 32'(state), 32'(0));
        check_output({tag, "_end_valid"}, 32'(rd_valid), 32'(0));
        if (timing) begin
            check_output({tag, "_first_latency"}, 32'(first_beat - ro_start), 32'(2));
            check_output({tag, "_back_to_back"}, 32'(last_beat - first_beat), 32'(len - 1));
        end
        rd_ready = 1'b1;
        exp_q.delete();
    endtask

    // Short software-triggered run used to confirm recovery after abort/reset.
    task automatic recovery_run(input string tag, input logic [DW-1:0] base);
        arm_run(11'd2, 12'h000, 1'b0);
        sw_trigger(1'b0, 12'h000);
        exp_q.push_back(base);
        exp_q.push_back(base + 12'd1);
        apply_stimulus(base, 1'b1);
        apply_stimulus(base + 12'd1, 1'b1);
        collect(tag, 2, 0, 1'b1);
    endtask

    initial begin
        $display("[TB] start");
        #12;
        check_output("reset_state", 32'(state), 32'(0));
        check_output("reset_valid", 32'(rd_valid), 32'(0));
        check_output("reset_last", 32'(rd_last), 32'(0));
        check_output("reset_done", 32'(done), 32'(0));
        check_output("reset_data", 32'(rd_data), 32'(0));
        #10 reset_n = 1'b1;
        tick();

        // sw_trig outside ARMED does nothing
        sw_trigger(1'b0, 12'h000);
        check_output("idle_swtrig_ignored", 32'(state), 32'(0));

        // 1. software trigger, ramp 100..107
        $display("[TB] test 1: software trigger");
        arm_run(11'd8, 12'h000, 1'b0);
        check_output("t1_armed", 32'(state), 32'(1));
        sw_trigger(1'b0, 12'h000);
        check_output("t1_capture", 32'(state), 32'(2));
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(12'(100 + i));
            apply_stimulus(12'(100 + i), 1'b1);
        end
        check_output("t1_readout", 32'(state), 32'(3));
        collect("t1", 8, 0, 1'b1);

        // 2a. level crossing from below
        $display("[TB] test 2: level crossing");
        arm_run(11'd2, 12'h800, 1'b1);
        apply_stimulus(12'h7F0, 1'b1);
        apply_stimulus(12'h7FF, 1'b1);
        check_output("t2a_below", 32'(state), 32'(1));
        apply_stimulus(12'h800, 1'b1);
        check_output("t2a_trig", 32'(state), 32'(2));
        apply_stimulus(12'h900, 1'b1);
        exp_q.push_back(12'h800);
        exp_q.push_back(12'h900);
        collect("t2a", 2, 0, 1'b0);

        // 2b. run starts above threshold: needs a dip first
        arm_run(11'd2, 12'h800, 1'b1);
        apply_stimulus(12'h900, 1'b1);
        apply_stimulus(12'h950, 1'b1);
        check_output("t2b_above", 32'(state), 32'(1));
        apply_stimulus(12'h7F0, 1'b1);
        check_output("t2b_dip", 32'(state), 32'(1));
        apply_stimulus(12'h810, 1'b1);
        check_output("t2b_trig", 32'(state), 32'(2));
        apply_stimulus(12'h820, 1'b1);
        exp_q.push_back(12'h810);
        exp_q.push_back(12'h820);
        collect("t2b", 2, 0, 1'b0);

        // 3. backpressure; also arm outside IDLE must not reload the length,
        //    and the trigger-cycle sample is index 0
        $display("[TB] test 3: backpressure");
        arm_run(11'd4, 12'h000, 1'b0);
        capture_len = 11'd1;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check_output("t3_rearm_state", 32'(state), 32'(1));
        sw_trigger(1'b1, 12'h111);
        check_output("t3_capture", 32'(state), 32'(2));
        apply_stimulus(12'h222, 1'b1);
        apply_stimulus(12'h333, 1'b1);
        apply_stimulus(12'h444, 1'b1);
        exp_q.push_back(12'h111);
        exp_q.push_back(12'h222);
        exp_q.push_back(12'h333);
        exp_q.push_back(12'h444);
        collect("t3", 4, 1, 1'b0);

        // 4. length clamping: 0 and DEPTH+5 both mean DEPTH
        $display("[TB] test 4: length clamp");
        arm_run(11'd0, 12'h000, 1'b0);
        sw_trigger(1'b0, 12'h000);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1)
                check_output("t4a_before_last", 32'(state), 32'(2));
            exp_q.push_back(12'(i * 7 + 3));
            apply_stimulus(12'(i * 7 + 3), 1'b1);
        end
        collect("t4a", DEPTH, 0, 1'b1);
        arm_run(11'(DEPTH + 5), 12'h000, 1'b0);
        sw_trigger(1'b0, 12'h000);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1)
                check_output("t4b_before_last", 32'(state), 32'(2));
            exp_q.push_back(12'(i * 13 + 5));
            apply_stimulus(12'(i * 13 + 5), 1'b1);
        end
        collect("t4b", DEPTH, 0, 1'b1);

        // 5. gapped input
        $display("[TB] test 5: gapped input");
        arm_run(11'd3, 12'h000, 1'b0);
        sw_trigger(1'b0, 12'h000);
        apply_stimulus(12'h0A1, 1'b1);
        apply_stimulus(12'hBAD, 1'b0);
        apply_stimulus(12'h0A2, 1'b1);
        check_output("t5_mid", 32'(state), 32'(2));
        apply_stimulus(12'hBAD, 1'b0);
        apply_stimulus(12'h0A3, 1'b1);
        exp_q.push_back(12'h0A1);
        exp_q.push_back(12'h0A2);
        exp_q.push_back(12'h0A3);
        collect("t5", 3, 0, 1'b1);

        // 6a. abort mid-CAPTURE
        $display("[TB] test 6: abort and reset");
        arm_run(11'd4, 12'h000, 1'b0);
        sw_trigger(1'b0, 12'h000);
        apply_stimulus(12'h301, 1'b1);
        apply_stimulus(12'h302, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_output("t6a_state", 32'(state), 32'(0));
        check_output("t6a_valid", 32'(rd_valid), 32'(0));
        tick();
        tick();
        check_output("t6a_stays_idle", 32'(state), 32'(0));
        recovery_run("t6a_rec", 12'h5A0);

        // 6b. abort coinciding with the final beat handshake
        arm_run(11'd2, 12'h000, 1'b0);
        sw_trigger(1'b0, 12'h000);
        apply_stimulus(12'h401, 1'b1);
        apply_stimulus(12'h402, 1'b1);
        rd_ready = 1'b1;
        for (int k = 0; k < 10 && !(rd_valid && rd_last); k++)
            tick();
        check_output("t6b_last_reached", 32'(rd_valid && rd_last), 32'(1));
        check_output("t6b_last_data", 32'(rd_data), 32'(12'h402));
        abort = 1'b1;
        #1;
        check_output("t6b_no_done", 32'(done), 32'(0));
        tick();
        abort = 1'b0;
        check_output("t6b_state", 32'(state), 32'(0));
        check_output("t6b_valid", 32'(rd_valid), 32'(0));
        check_output("t6b_last", 32'(rd_last), 32'(0));
        recovery_run("t6b_rec", 12'h6B0);

        // 6c. asynchronous reset mid-READOUT
        arm_run(11'd4, 12'h000, 1'b0);
        sw_trigger(1'b0, 12'h000);
        for (int i = 0; i < 4; i++)
            apply_stimulus(12'(12'h700 + i), 1'b1);
        rd_ready = 1'b0;
        for (int k = 0; k < 10 && !rd_valid; k++)
            tick();
        check_output("t6c_pre_valid", 32'(rd_valid), 32'(1));
        #2 reset_n = 1'b0;
        #1;
        check_output("t6c_async_state", 32'(state), 32'(0));
        check_output("t6c_async_valid", 32'(rd_valid), 32'(0));
        check_output("t6c_async_done", 32'(done), 32'(0));
        @(negedge clk);
        reset_n = 1'b1;
        rd_ready = 1'b1;
        tick();
        check_output("t6c_after_state", 32'(state), 32'(0));
        recovery_run("t6c_rec", 12'h7C0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] timeout");
    end

endmodule
